// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - shared LPC cycle types, SYNC codes, status codes and FSM states
package lpc_pkg;

  localparam logic [1:0] CT_IO  = 2'b00;
  localparam logic [1:0] CT_MEM = 2'b01;
  localparam logic [1:0] CT_DMA = 2'b10;

  localparam logic [3:0] SYNC_READY = 4'h0;
  localparam logic [3:0] SYNC_SWAIT = 4'h5;
  localparam logic [3:0] SYNC_LWAIT = 4'h6;
  localparam logic [3:0] SYNC_ERR   = 4'hA;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_SYNC_ERR  = 2'b01,
    ST_TIMEOUT   = 2'b10,
    ST_PROTO_ERR = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_WDATA,
    S_TAR,
    S_SYNC,
    S_RDATA
  } state_t;

endpackage

// File: rtl/lpc_cycle_decoder_if.sv
// rtl/lpc_cycle_decoder_if.sv - LPC bus sample inputs and decoded record outputs
interface lpc_cycle_decoder_if;

  logic [3:0]  lpc_ad;
  logic        lpc_frame;
  logic [3:0]  out_cyctype_dir;
  logic [31:0] out_addr;
  logic [7:0]  out_data;
  logic [1:0]  out_status;
  logic        out_clock_enable;

  modport master (
    output lpc_ad, lpc_frame,
    input  out_cyctype_dir, out_addr, out_data, out_status, out_clock_enable
  );

  modport slave (
    input  lpc_ad, lpc_frame,
    output out_cyctype_dir, out_addr, out_data, out_status, out_clock_enable
  );

endinterface

// File: rtl/lpc_sync_monitor.sv
// rtl/lpc_sync_monitor.sv - SYNC nibble classifier and consecutive wait counter
module lpc_sync_monitor
  import lpc_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       sample,
  input  logic [3:0] ad,
  output logic       sync_ready,
  output logic       sync_wait,
  output logic       sync_err,
  output logic       sync_proto,
  output logic       sync_timeout
);

  logic [WAIT_W-1:0] wait_cnt;
  logic              is_wait;
  logic              last_wait;

  always_comb begin
    is_wait      = (ad == SYNC_SWAIT) || (ad == SYNC_LWAIT);
    last_wait    = (wait_cnt == WAIT_W'(MAX_WAIT - 1));
    sync_ready   = sample && (ad == SYNC_READY);
    sync_err     = sample && (ad == SYNC_ERR);
    sync_proto   = sample && !is_wait && (ad != SYNC_READY) && (ad != SYNC_ERR);
    // The wait that brings the count to MAX_WAIT is reported as timeout, not wait
    sync_wait    = sample && is_wait && !last_wait;
    sync_timeout = sample && is_wait && last_wait;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (sync_wait) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lpc_cycle_decoder.sv
// rtl/lpc_cycle_decoder.sv - passive LPC I/O and memory cycle decoder emitting one record per cycle
module lpc_cycle_decoder
  import lpc_pkg::*;
#(
  parameter bit MEM_ENABLE = 1'b1,
  parameter int MAX_WAIT   = 16
) (
  input logic               lpc_clock,
  input logic               lpc_reset,
  lpc_cycle_decoder_if.slave bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t      state;
  state_t      state_next;
  logic        start_ok;
  logic [3:0]  ctdir;
  logic [31:0] addr;
  logic [7:0]  data;
  logic [2:0]  nib_cnt;
  logic        half;

  logic        emit;
  status_t     emit_status;
  logic [7:0]  emit_data;

  logic [3:0]  rec_ctdir;
  logic [31:0] rec_addr;
  logic [7:0]  rec_data;
  logic [1:0]  rec_status;
  logic        rec_valid;

  logic sync_ready, sync_wait, sync_err, sync_proto, sync_timeout;

  lpc_sync_monitor #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_sync (
    .clk          (lpc_clock),
    .rst_n        (lpc_reset),
    .clear        (state != S_SYNC),
    .sample       ((state == S_SYNC) && bus.lpc_frame),
    .ad           (bus.lpc_ad),
    .sync_ready   (sync_ready),
    .sync_wait    (sync_wait),
    .sync_err     (sync_err),
    .sync_proto   (sync_proto),
    .sync_timeout (sync_timeout)
  );

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame low outranks everything, including a completing nibble
  always_comb begin
    state_next  = state;
    emit        = 1'b0;
    emit_status = ST_OK;
    emit_data   = data;
    if (!bus.lpc_frame) begin
      state_next = S_START;
    end else begin
      case (state)
        S_IDLE: state_next = S_IDLE;
        S_START: begin
          state_next = S_IDLE;
          if (start_ok) begin
            case (bus.lpc_ad[3:2])
              CT_IO:   state_next = S_ADDR;
              CT_MEM:  state_next = MEM_ENABLE ? S_ADDR : S_IDLE;
              CT_DMA:  state_next = S_IDLE;
              default: state_next = S_IDLE;
            endcase
          end
        end
        S_ADDR: begin
          if (nib_cnt == 3'd0) begin
            state_next = ctdir[1] ? S_WDATA : S_TAR;
          end
        end
        S_WDATA: begin
          if (half) begin
            state_next = S_TAR;
          end
        end
        S_TAR: begin
          if (half) begin
            state_next = S_SYNC;
          end
        end
        S_SYNC: begin
          if (sync_ready) begin
            if (ctdir[1]) begin
              emit       = 1'b1;
              state_next = S_IDLE;
            end else begin
              state_next = S_RDATA;
            end
          end else if (sync_timeout) begin
            emit        = 1'b1;
            emit_status = ST_TIMEOUT;
            state_next  = S_IDLE;
          end else if (sync_err) begin
            emit        = 1'b1;
            emit_status = ST_SYNC_ERR;
            state_next  = S_IDLE;
          end else if (sync_proto) begin
            emit        = 1'b1;
            emit_status = ST_PROTO_ERR;
            state_next  = S_IDLE;
          end else if (sync_wait) begin
            state_next = S_SYNC;
          end
        end
        S_RDATA: begin
          if (half) begin
            emit       = 1'b1;
            emit_data  = {bus.lpc_ad, data[3:0]};
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      start_ok <= 1'b0;
      ctdir    <= '0;
      addr     <= '0;
      data     <= '0;
      nib_cnt  <= '0;
    end else if (!bus.lpc_frame) begin
      start_ok <= (bus.lpc_ad == 4'h0);
    end else begin
      case (state)
        S_START: begin
          ctdir   <= bus.lpc_ad;
          addr    <= '0;
          data    <= '0;
          nib_cnt <= (bus.lpc_ad[3:2] == CT_MEM) ? 3'd7 : 3'd3;
        end
        S_ADDR: begin
          addr    <= {addr[27:0], bus.lpc_ad};
          nib_cnt <= nib_cnt - 3'd1;
        end
        S_WDATA, S_RDATA: begin
          if (!half) begin
            data[3:0] <= bus.lpc_ad;
          end else begin
            data[7:4] <= bus.lpc_ad;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Two-nibble phases (WDATA, TAR, RDATA) share one phase bit, restarted on every state change
  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      half <= 1'b0;
    end else if (state_next != state) begin
      half <= 1'b0;
    end else if ((state == S_WDATA) || (state == S_TAR) || (state == S_RDATA)) begin
      half <= ~half;
    end
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      rec_valid  <= 1'b0;
      rec_ctdir  <= '0;
      rec_addr   <= '0;
      rec_data   <= '0;
      rec_status <= '0;
    end else begin
      rec_valid <= emit;
      if (emit) begin
        rec_ctdir  <= ctdir;
        rec_addr   <= addr;
        rec_data   <= emit_data;
        rec_status <= emit_status;
      end
    end
  end

  assign bus.out_clock_enable = rec_valid;
  assign bus.out_cyctype_dir  = rec_ctdir;
  assign bus.out_addr         = rec_addr;
  assign bus.out_data         = rec_data;
  assign bus.out_status       = rec_status;

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// tb/tb_lpc_cycle_decoder.sv - scoreboard bench for lpc_cycle_decoder (MEM_ENABLE=1 and 0 side by side)
module tb_lpc_cycle_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lpc_cycle_decoder_if bus_a ();
  lpc_cycle_decoder_if bus_b ();

  assign bus_b.lpc_ad    = bus_a.lpc_ad;
  assign bus_b.lpc_frame = bus_a.lpc_frame;

  lpc_cycle_decoder #(.MEM_ENABLE(1'b1), .MAX_WAIT(8)) dut_a (
    .lpc_clock (clk),
    .lpc_reset (rst_n),
    .bus       (bus_a.slave)
  );

  lpc_cycle_decoder #(.MEM_ENABLE(1'b0), .MAX_WAIT(8)) dut_b (
    .lpc_clock (clk),
    .lpc_reset (rst_n),
    .bus       (bus_b.slave)
  );

  typedef struct packed {
    logic [3:0]  ct;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [1:0]  st;
    logic [7:0]  lat;
  } rec_t;

  rec_t       q_a[$];
  rec_t       q_b[$];
  logic [4:0] stim[$];
  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int ct_edge = 0;
  int ct_idx = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    rec_t e;
    if (bus_a.out_clock_enable === 1'b1) begin
      if (q_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse_a: got addr %h status %b expected no pulse",
                 bus_a.out_addr, bus_a.out_status);
      end else begin
        e = q_a.pop_front();
        check("record_a", {bus_a.out_cyctype_dir, bus_a.out_addr, bus_a.out_data, bus_a.out_status},
              {e.ct, e.addr, e.data, e.st});
        if (e.lat != 8'd0) check("latency_a", 64'(edge_cnt - ct_edge + 1), 64'(e.lat));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    rec_t e;
    if (bus_b.out_clock_enable === 1'b1) begin
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse_b: got addr %h status %b expected no pulse",
                 bus_b.out_addr, bus_b.out_status);
      end else begin
        e = q_b.pop_front();
        check("record_b", {bus_b.out_cyctype_dir, bus_b.out_addr, bus_b.out_data, bus_b.out_status},
              {e.ct, e.addr, e.data, e.st});
      end
    end
  end

  task automatic add(input logic f, input logic [3:0] a);
    stim.push_back({f, a});
  endtask

  task automatic add_hex(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) add(1'b1, v[4*i +: 4]);
  endtask

  task automatic add_byte(input logic [7:0] b);
    add(1'b1, b[3:0]);
    add(1'b1, b[7:4]);
  endtask

  // Full cycle: START 0000, CT, address, data/TAR/SYNC in bus order, then two idle clocks
  task automatic cycle(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] d,
                       input int waits, input logic [3:0] wcode, input logic [3:0] fsync);
    add(1'b0, 4'h0);
    ct_idx = stim.size();
    add(1'b1, ct);
    add_hex(a, (ct[3:2] == 2'b01) ? 8 : 4);
    if (ct[1]) add_byte(d);
    add(1'b1, 4'hf);
    add(1'b1, 4'hf);
    for (int i = 0; i < waits; i++) add(1'b1, wcode);
    add(1'b1, fsync);
    if (!ct[1] && fsync == 4'h0) add_byte(d);
    add(1'b1, 4'hf);
    add(1'b1, 4'hf);
  endtask

  task automatic expect_rec(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] d,
                            input logic [1:0] st, input logic [7:0] lat, input bit both);
    rec_t e;
    e = '{ct: ct, addr: a, data: d, st: st, lat: lat};
    q_a.push_back(e);
    if (both) q_b.push_back(e);
  endtask

  task automatic play();
    for (int i = 0; i < stim.size(); i++) begin
      @(negedge clk);
      bus_a.lpc_frame = stim[i][4];
      bus_a.lpc_ad    = stim[i][3:0];
      if (i == ct_idx) ct_edge = edge_cnt + 1;
    end
    stim.delete();
    ct_idx = -1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    bus_a.lpc_frame = 1'b1;
    bus_a.lpc_ad    = 4'hf;
    repeat (3) @(negedge clk);
    check("reset_a", {bus_a.out_clock_enable, bus_a.out_cyctype_dir, bus_a.out_addr,
                      bus_a.out_data, bus_a.out_status}, 64'd0);
    check("reset_b", {bus_b.out_clock_enable, bus_b.out_cyctype_dir, bus_b.out_addr,
                      bus_b.out_data, bus_b.out_status}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    expect_rec(4'h0, 32'h0000_7fe5, 8'h6c, 2'b00, 8'd10, 1'b1);
    cycle(4'h0, 32'h7fe5, 8'h6c, 0, 4'h5, 4'h0);
    play();

    expect_rec(4'h6, 32'hfeed_c0de, 8'ha5, 2'b00, 8'd0, 1'b0);
    cycle(4'h6, 32'hfeed_c0de, 8'ha5, 3, 4'h5, 4'h0);
    play();

    expect_rec(4'h4, 32'h000f_fff0, 8'hc3, 2'b00, 8'd14, 1'b0);
    cycle(4'h4, 32'h000f_fff0, 8'hc3, 0, 4'h5, 4'h0);
    play();

    expect_rec(4'h0, 32'h0000_0060, 8'h19, 2'b00, 8'd0, 1'b1);
    cycle(4'h0, 32'h0060, 8'h19, 7, 4'h5, 4'h0);
    play();

    expect_rec(4'h0, 32'h0000_1234, 8'h00, 2'b10, 8'd0, 1'b1);
    cycle(4'h0, 32'h1234, 8'hde, 8, 4'h6, 4'h0);
    play();

    expect_rec(4'h2, 32'h0000_0080, 8'h12, 2'b01, 8'd0, 1'b1);
    cycle(4'h2, 32'h0080, 8'h12, 0, 4'h5, 4'ha);
    play();

    expect_rec(4'h2, 32'h0000_0081, 8'h34, 2'b11, 8'd0, 1'b1);
    cycle(4'h2, 32'h0081, 8'h34, 0, 4'h5, 4'hf);
    play();

    add(1'b0, 4'h0); add(1'b1, 4'h0); add(1'b1, 4'h1); add(1'b1, 4'h2);
    for (int i = 0; i < 4; i++) add(1'b0, 4'hf);
    add(1'b1, 4'hf);
    expect_rec(4'h2, 32'h0000_002e, 8'h55, 2'b00, 8'd0, 1'b1);
    cycle(4'h2, 32'h002e, 8'h55, 0, 4'h5, 4'h0);
    play();

    add(1'b0, 4'h3);
    expect_rec(4'h0, 32'h0000_0abc, 8'h7e, 2'b00, 8'd10, 1'b1);
    cycle(4'h0, 32'h0abc, 8'h7e, 0, 4'h5, 4'h0);
    play();

    add(1'b0, 4'h0); add(1'b0, 4'h3); add(1'b1, 4'h0); add_hex(32'h0abc, 4);
    add(1'b1, 4'hf); add(1'b1, 4'hf); add(1'b1, 4'h0); add_byte(8'h11); add(1'b1, 4'hf);
    add(1'b0, 4'h1); add(1'b1, 4'h0); add_hex(32'h1111, 4);
    add(1'b1, 4'hf); add(1'b1, 4'hf); add(1'b1, 4'h0); add_byte(8'h22); add(1'b1, 4'hf);
    play();
    cycle(4'h8, 32'h1234, 8'h33, 0, 4'h5, 4'h0);
    play();

    add(1'b0, 4'h0); add(1'b1, 4'h2); add_hex(32'h0044, 4); add_byte(8'h77);
    add(1'b1, 4'hf); add(1'b1, 4'hf);
    expect_rec(4'h2, 32'h0000_0045, 8'h88, 2'b00, 8'd0, 1'b1);
    cycle(4'h2, 32'h0045, 8'h88, 0, 4'h5, 4'h0);
    play();

    add(1'b0, 4'h0); add(1'b1, 4'h2); add_hex(32'h0099, 4); add(1'b1, 4'h3);
    play();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_a", {bus_a.out_clock_enable, bus_a.out_cyctype_dir, bus_a.out_addr,
                         bus_a.out_data, bus_a.out_status}, 64'd0);
    check("midreset_b", {bus_b.out_clock_enable, bus_b.out_cyctype_dir, bus_b.out_addr,
                         bus_b.out_data, bus_b.out_status}, 64'd0);
    bus_a.lpc_frame = 1'b1;
    bus_a.lpc_ad    = 4'hf;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    expect_rec(4'h0, 32'h0000_03f8, 8'h41, 2'b00, 8'd10, 1'b1);
    cycle(4'h0, 32'h03f8, 8'h41, 0, 4'h5, 4'h0);
    play();

    repeat (10) @(negedge clk);
    check("leftover_a", 64'(q_a.size()), 64'd0);
    check("leftover_b", 64'(q_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
